// File: rtl/aco_pkg.sv
// Shared constants and state encoding for the acoustic front-end frame controller.
package aco_pkg;

    localparam int I_BW         = 8;
    localparam int N_COEF       = 13;
    localparam int O_BW         = I_BW * N_COEF;
    localparam int N_FRAMES     = 50;
    localparam int FRAME_IDX_BW = $clog2(N_FRAMES);
    localparam int CC_BW        = $clog2(N_COEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/aco_hold_reg.sv
// One-entry ready/valid holding register; flags an overflow when a frame arrives while full and not draining.
module aco_hold_reg
    import aco_pkg::*;
#(
    parameter int DATA_W = O_BW,
    parameter int IDX_W  = FRAME_IDX_BW
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              load_vld_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic [IDX_W-1:0]  load_idx_i,
    input  logic              load_last_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              last_o,
    output logic              valid_o,
    output logic              ovf_o
);

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [IDX_W-1:0]  idx_p1;
    logic              last_p1;
    logic              take;

    // A draining entry frees the slot in the same cycle, so load and drain overlap without a bubble.
    assign take  = load_vld_i & (~vld_p1 | ready_i);
    assign ovf_o = load_vld_i & vld_p1 & ~ready_i;

    // Stage p1: held frame
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            idx_p1  <= '0;
            last_p1 <= 1'b0;
        end else begin
            if (flush_i)
                vld_p1 <= 1'b0;
            else if (take)
                vld_p1 <= 1'b1;
            else if (ready_i)
                vld_p1 <= 1'b0;

            if (take) begin
                data_p1 <= load_data_i;
                idx_p1  <= load_idx_i;
                last_p1 <= load_last_i;
            end
        end
    end

    assign valid_o = vld_p1;
    assign data_o  = data_p1;
    assign idx_o   = idx_p1;
    assign last_o  = last_p1;

endmodule

// File: rtl/aco_frame_ctrl.sv
// Packer sequencing, coefficient framing check and window tagging for the CNN input stream.
// Optional ACO_FRAME_STATS_EN adds saturating drop / framing-error counters.
module aco_frame_ctrl
    import aco_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic                    coef_valid_i,
    input  logic                    coef_last_i,
    input  logic [O_BW-1:0]         pk_data_i,
    input  logic                    pk_valid_i,
    output logic                    pk_en_o,
    output logic [O_BW-1:0]         data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    last_o,
    output logic [FRAME_IDX_BW-1:0] frame_idx_o,
    output logic                    err_o,
`ifdef ACO_FRAME_STATS_EN
    output logic [7:0]              drop_cnt_o,
    output logic [7:0]              ferr_cnt_o,
`endif
    input  logic                    err_clr_i
);

    localparam logic [CC_BW-1:0]        CC_LAST   = CC_BW'(N_COEF - 1);
    localparam logic [FRAME_IDX_BW-1:0] WIDX_LAST = FRAME_IDX_BW'(N_FRAMES - 1);

    state_e                  state_q, state_d;
    logic [CC_BW-1:0]        cc_q, cc_d;
    logic [FRAME_IDX_BW-1:0] widx_q;
    logic                    run_act;
    logic                    ferr;
    logic                    pk_load;
    logic                    ovf;
    logic                    err_q;

    assign run_act = (state_q == RUN) && en_i;
    assign pk_load = run_act && pk_valid_i;

    always_comb begin
        ferr = 1'b0;
        if (run_act)
            ferr = (coef_last_i && (cc_q != CC_LAST)) ||
                   ((cc_q == CC_LAST) && coef_valid_i && !coef_last_i);
    end

    always_comb begin
        state_d = state_q;
        cc_d    = '0;
        pk_en_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i)
                    state_d = RUN;
            end
            RUN: begin
                pk_en_o = 1'b1;
                // A gap leaves cc_d at zero, matching the packer discarding a partial frame.
                if (ferr)
                    state_d = FLUSH;
                else if (coef_valid_i)
                    cc_d = (cc_q == CC_LAST) ? '0 : cc_q + 1'b1;
            end
            FLUSH: begin
                state_d = en_i ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!en_i) begin
            state_d = IDLE;
            cc_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cc_q    <= '0;
            widx_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            // Index advances even on a dropped frame so it stays aligned to time.
            if (!en_i)
                widx_q <= '0;
            else if (pk_load)
                widx_q <= (widx_q == WIDX_LAST) ? '0 : widx_q + 1'b1;
            if (ferr || ovf)
                err_q <= 1'b1;
            else if (err_clr_i)
                err_q <= 1'b0;
        end
    end

    assign err_o = err_q;

    aco_hold_reg #(
        .DATA_W (O_BW),
        .IDX_W  (FRAME_IDX_BW)
    ) u_hold (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (~en_i),
        .load_vld_i  (pk_load),
        .load_data_i (pk_data_i),
        .load_idx_i  (widx_q),
        .load_last_i (widx_q == WIDX_LAST),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .idx_o       (frame_idx_o),
        .last_o      (last_o),
        .valid_o     (valid_o),
        .ovf_o       (ovf)
    );

`ifdef ACO_FRAME_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

    logic [7:0] drop_cnt_q, ferr_cnt_q;

    // A clear coinciding with a new event keeps that event counted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_q <= '0;
            ferr_cnt_q <= '0;
        end else if (err_clr_i) begin
            drop_cnt_q <= {7'd0, ovf};
            ferr_cnt_q <= {7'd0, ferr};
        end else begin
            drop_cnt_q <= sat_inc(drop_cnt_q, ovf);
            ferr_cnt_q <= sat_inc(ferr_cnt_q, ferr);
        end
    end

    assign drop_cnt_o = drop_cnt_q;
    assign ferr_cnt_o = ferr_cnt_q;
`endif

endmodule

// File: tb/tb_aco_frame_ctrl.sv
// Self-checking bench for aco_frame_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_aco_frame_ctrl;
    import aco_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    rst_n_i = 1'b0;
    logic                    en_i = 1'b0;
    logic                    coef_valid_i = 1'b0;
    logic                    coef_last_i = 1'b0;
    logic [O_BW-1:0]         pk_data_i = '0;
    logic                    pk_valid_i = 1'b0;
    logic                    ready_i = 1'b0;
    logic                    err_clr_i = 1'b0;
    logic                    pk_en_o, valid_o, last_o, err_o;
    logic [O_BW-1:0]         data_o;
    logic [FRAME_IDX_BW-1:0] frame_idx_o;
`ifdef ACO_FRAME_STATS_EN
    logic [7:0]              drop_cnt_o, ferr_cnt_o;
`endif

    localparam logic [O_BW-1:0] NOM = 104'h0102030405060708090A0B0C0D;

    aco_frame_ctrl dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_i         (en_i),
        .coef_valid_i (coef_valid_i),
        .coef_last_i  (coef_last_i),
        .pk_data_i    (pk_data_i),
        .pk_valid_i   (pk_valid_i),
        .pk_en_o      (pk_en_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .last_o       (last_o),
        .frame_idx_o  (frame_idx_o),
        .err_o        (err_o),
`ifdef ACO_FRAME_STATS_EN
        .drop_cnt_o   (drop_cnt_o),
        .ferr_cnt_o   (ferr_cnt_o),
`endif
        .err_clr_i    (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [O_BW-1:0] act, input logic [O_BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = disabled, 1 = running, 2 = one-cycle packer flush
    int              m_mode, m_cc, m_widx, m_hi, m_drop, m_ferr;
    bit              m_hv, m_hl, m_err;
    logic [O_BW-1:0] m_hd;

    task automatic model_step();
        bit run, ferr, ovf, load;
        if (!rst_n_i) begin
            m_mode = 0; m_cc = 0; m_widx = 0; m_hv = 0; m_hl = 0; m_hi = 0;
            m_hd = '0; m_err = 0; m_drop = 0; m_ferr = 0;
            return;
        end
        run  = (m_mode == 1) && en_i;
        ferr = run && ((coef_last_i && m_cc != N_COEF - 1) ||
                       (m_cc == N_COEF - 1 && coef_valid_i && !coef_last_i));
        ovf  = run && pk_valid_i && m_hv && !ready_i;
        load = run && pk_valid_i && (!m_hv || ready_i);
        if (ferr || ovf) m_err = 1;
        else if (err_clr_i) m_err = 0;
        if (err_clr_i) begin
            m_drop = ovf ? 1 : 0;
            m_ferr = ferr ? 1 : 0;
        end else begin
            if (ovf && m_drop < 255) m_drop++;
            if (ferr && m_ferr < 255) m_ferr++;
        end
        if (!en_i) m_hv = 0;
        else if (load) begin
            m_hv = 1; m_hd = pk_data_i; m_hi = m_widx; m_hl = (m_widx == N_FRAMES - 1);
        end else if (m_hv && ready_i) m_hv = 0;
        if (!en_i) m_widx = 0;
        else if (run && pk_valid_i) m_widx = (m_widx + 1) % N_FRAMES;
        if (run && !ferr && coef_valid_i) m_cc = (m_cc + 1) % N_COEF;
        else m_cc = 0;
        if (!en_i) m_mode = 0;
        else if (m_mode == 1 && ferr) m_mode = 2;
        else m_mode = 1;
    endtask

    logic [O_BW-1:0] acc_d[$];
    int              acc_i[$];
    bit              acc_l[$];
    int              pk_low = 0;

    always @(posedge clk_i) begin
        if (rst_n_i && valid_o && ready_i) begin
            acc_d.push_back(data_o);
            acc_i.push_back(int'(frame_idx_o));
            acc_l.push_back(last_o);
        end
        model_step();
        #1;
        if (!pk_en_o) pk_low++;
        check_int("pk_en", int'(pk_en_o), (m_mode == 1) ? 1 : 0);
        check_int("valid", int'(valid_o), int'(m_hv));
        check_int("err", int'(err_o), int'(m_err));
        if (m_hv) begin
            check("data", data_o, m_hd);
            check_int("idx", int'(frame_idx_o), m_hi);
            check_int("last", int'(last_o), int'(m_hl));
        end
`ifdef ACO_FRAME_STATS_EN
        check_int("drop_cnt", int'(drop_cnt_o), m_drop);
        check_int("ferr_cnt", int'(ferr_cnt_o), m_ferr);
`endif
    end

    function automatic logic [O_BW-1:0] frame_data(input int base);
        logic [O_BW-1:0] d = '0;
        for (int i = 1; i <= N_COEF; i++) d = {d[O_BW-9:0], 8'(base + i)};
        return d;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            coef_valid_i = 0; coef_last_i = 0; pk_valid_i = 0;
        end
    endtask

    // Stands in for the packer: len coefficients, then a packed frame one cycle later if complete.
    task automatic send_frame(input int len, input int base, input bit rdy_on_pkv);
        for (int i = 1; i <= len; i++) begin
            @(negedge clk_i);
            coef_valid_i = 1; coef_last_i = (i == len); pk_valid_i = 0;
        end
        @(negedge clk_i);
        coef_valid_i = 0; coef_last_i = 0;
        if (len == N_COEF) begin
            pk_valid_i = 1; pk_data_i = frame_data(base);
            if (rdy_on_pkv) ready_i = 1;
        end
        @(negedge clk_i);
        pk_valid_i = 0;
        if (rdy_on_pkv) ready_i = 0;
    endtask

    task automatic clear_acc();
        acc_d.delete(); acc_i.delete(); acc_l.delete();
    endtask

    task automatic pulse_clr();
        @(negedge clk_i); err_clr_i = 1;
        @(negedge clk_i); err_clr_i = 0;
    endtask

    initial begin
        int nlast;
        repeat (2) @(negedge clk_i);
        check_int("rst_valid", int'(valid_o), 0);
        check("rst_data", data_o, '0);
        check_int("rst_idx", int'(frame_idx_o), 0);
        check_int("rst_last", int'(last_o), 0);
        check_int("rst_err", int'(err_o), 0);
        check_int("rst_pk_en", int'(pk_en_o), 0);

        // Nominal
        rst_n_i = 1;
        @(negedge clk_i); en_i = 1; ready_i = 1;
        idle(2);
        clear_acc();
        repeat (3) send_frame(N_COEF, 0, 0);
        idle(2);
        check_int("nom_count", acc_d.size(), 3);
        for (int i = 0; i < acc_d.size(); i++) begin
            check("nom_data", acc_d[i], NOM);
            check_int("nom_idx", acc_i[i], i);
            check_int("nom_last", int'(acc_l[i]), 0);
        end
        check_int("nom_err", int'(err_o), 0);

        // Window wrap: 48 more frames, 51 in total
        clear_acc();
        for (int f = 0; f < 48; f++) send_frame(N_COEF, f * 3, 0);
        idle(2);
        check_int("wrap_count", acc_d.size(), 48);
        nlast = 0;
        for (int i = 0; i < acc_i.size(); i++) begin
            check_int("wrap_idx", acc_i[i], (i + 3) % N_FRAMES);
            if (acc_l[i]) begin
                nlast++;
                check_int("wrap_last_idx", acc_i[i], 49);
            end
        end
        check_int("wrap_nlast", nlast, 1);
        if (acc_i.size() == 48) begin
            check_int("wrap_f51_idx", acc_i[47], 0);
            check_int("wrap_f51_last", int'(acc_l[47]), 0);
        end

        // Short frame
        clear_acc();
        pk_low = 0;
        send_frame(9, 8'h40, 0);
        idle(3);
        check_int("short_err", int'(err_o), 1);
        check_int("short_pk_low", pk_low, 1);
        check_int("short_noframe", acc_d.size(), 0);
        send_frame(N_COEF, 8'h50, 0);
        idle(2);
        check_int("short_next_cnt", acc_d.size(), 1);
        if (acc_d.size() > 0) begin
            check_int("short_next_idx", acc_i[0], 1);
            check("short_next_data", acc_d[0], frame_data(8'h50));
        end
        pulse_clr();
        @(negedge clk_i);
        check_int("clr_err", int'(err_o), 0);

        // Backpressure
        clear_acc();
        ready_i = 0;
        send_frame(N_COEF, 8'h60, 0);
        send_frame(N_COEF, 8'h70, 0);
        idle(2);
        check_int("bp_valid", int'(valid_o), 1);
        check("bp_data", data_o, frame_data(8'h60));
        check_int("bp_idx", int'(frame_idx_o), 2);
        check_int("bp_err", int'(err_o), 1);
`ifdef ACO_FRAME_STATS_EN
        check_int("bp_drop_cnt", int'(drop_cnt_o), 1);
`endif
        ready_i = 1;
        idle(2);
        send_frame(N_COEF, 8'h80, 0);
        idle(2);
        check_int("bp_count", acc_d.size(), 2);
        if (acc_d.size() == 2) begin
            check("bp_first_data", acc_d[0], frame_data(8'h60));
            check_int("bp_first_idx", acc_i[0], 2);
            check_int("bp_skip_idx", acc_i[1], 4);
        end
        pulse_clr();

        // Drain and load in the same cycle
        ready_i = 0;
        send_frame(N_COEF, 8'h90, 0);
        clear_acc();
        send_frame(N_COEF, 8'hA0, 1);
        check_int("dl_valid", int'(valid_o), 1);
        check("dl_data", data_o, frame_data(8'hA0));
        check_int("dl_idx", int'(frame_idx_o), 6);
        check_int("dl_err", int'(err_o), 0);
        check_int("dl_acc", acc_d.size(), 1);
        if (acc_d.size() == 1) check("dl_acc_data", acc_d[0], frame_data(8'h90));

        // Asynchronous reset mid-frame
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i); coef_valid_i = 1;
        end
        @(negedge clk_i); coef_valid_i = 0;
        #2 rst_n_i = 0;
        #1;
        check_int("arst_valid", int'(valid_o), 0);
        check("arst_data", data_o, '0);
        check_int("arst_idx", int'(frame_idx_o), 0);
        check_int("arst_last", int'(last_o), 0);
        check_int("arst_err", int'(err_o), 0);
        check_int("arst_pk_en", int'(pk_en_o), 0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1; ready_i = 1;
        idle(2);
        clear_acc();
        send_frame(N_COEF, 8'hB0, 0);
        idle(2);
        check_int("arst_count", acc_d.size(), 1);
        if (acc_d.size() == 1) begin
            check_int("arst_next_idx", acc_i[0], 0);
            check("arst_next_data", acc_d[0], frame_data(8'hB0));
        end

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i);
            en_i         = ($urandom_range(99) < 98);
            coef_valid_i = ($urandom_range(99) < 85);
            coef_last_i  = coef_valid_i && ((m_cc == N_COEF - 1) ? ($urandom_range(9) < 9)
                                                                  : ($urandom_range(99) < 3));
            pk_valid_i   = ($urandom_range(99) < 15);
            pk_data_i    = O_BW'({$urandom(), $urandom(), $urandom(), $urandom()});
            ready_i      = ($urandom_range(99) < 55);
            err_clr_i    = ($urandom_range(99) < 4);
        end
        @(negedge clk_i);
        err_clr_i = 0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aco_frame_ctrl.md
Name: aco_frame_ctrl

Overview:
- Sequences the acoustic front-end coefficient packer and enforces frame integrity on the serial coefficient stream.
- Drives the packer enable, checks coefficients per frame, buffers each packed frame in a one-entry holding register with ready/valid toward the CNN input, and tags the final frame of each N_FRAMES-frame inference window.
- Sits between the DCT/quantiser output and the first convolution layer's frame buffer.

Parameters:
- I_BW, 8: coefficient width in bits.
- N_COEF, 13: coefficients per frame.
- O_BW, I_BW*N_COEF (104): packed frame width.
- N_FRAMES, 50: frames per inference window.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  block enable from the top-level controller.
- coef_valid_i  in  1  coefficient strobe, monitored in parallel with the packer.
- coef_last_i  in  1  last coefficient of the frame, from the DCT.
- pk_data_i  in  O_BW  packed frame from the packer.
- pk_valid_i  in  1  packer output valid.
- pk_en_o  out  1  packer enable.
- data_o  out  O_BW  held frame.
- valid_o  out  1  frame available.
- ready_i  in  1  downstream accept.
- last_o  out  1  held frame is the last frame of the window.
- frame_idx_o  out  6  index (0..N_FRAMES-1) of the held frame.
- err_o  out  1  sticky error: framing error or overflow.
- err_clr_i  in  1  clears err_o.

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE, pk_en_o=0, valid_o=0, data_o=0, last_o=0, frame_idx_o=0, err_o=0. All internal counters are 0.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: pk_en_o=0. Go to RUN on the first cycle en_i=1.
  - RUN: pk_en_o=1.
    - The coefficient counter cc (0..N_COEF-1) increments on coef_valid_i and wraps to 0 after N_COEF-1.
    - A gap (coef_valid_i=0) with cc!=0 resets cc to 0. This mirrors the packer, which discards a partial frame on a gap.
    - Framing error: coef_last_i=1 with cc!=N_COEF-1, or cc==N_COEF-1 with coef_valid_i=1 and coef_last_i=0. On a framing error: set err_o, reset cc, go to FLUSH.
  - FLUSH: pk_en_o=0 for exactly one cycle, which clears the packer. Then go to RUN if en_i=1, else IDLE. Coefficients arriving during FLUSH are ignored.
  - en_i=0 in any state: go to IDLE next cycle, drop the held frame (valid_o=0), reset the window index to 0. err_o is held.
- Holding register, accepted on pk_valid_i in RUN:
  - If empty, or draining this cycle (valid_o & ready_i), load: data_o<=pk_data_i, frame_idx_o<=window index, last_o<=(window index==N_FRAMES-1). valid_o=1 the next cycle.
  - Load latency: 1 cycle from pk_valid_i.
  - Simultaneous drain and load: the new frame replaces the old with no bubble.
  - Full and not draining: the new frame is dropped (overflow), err_o is set, and the window index still advances so indices stay aligned to time.
- Window index: increments on each pk_valid_i in RUN and wraps from N_FRAMES-1 to 0.
- Handshake: data_o, last_o and frame_idx_o are stable while valid_o=1 and ready_i=0. valid_o falls the cycle after the accept unless a new frame is loaded.
- err_o: sticky until err_clr_i=1. If err_clr_i and a new error occur in the same cycle, the set wins.
- pk_valid_i outside RUN is ignored.

Optional Feature:
- ACO_FRAME_STATS_EN defined:
  - Adds outputs drop_cnt_o[7:0] (overflow drops) and ferr_cnt_o[7:0] (framing errors).
  - Both counters saturate at 255 and are cleared by err_clr_i or reset.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package aco_pkg holds: I_BW, N_COEF, O_BW, N_FRAMES, state encoding (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2), and FRAME_IDX_BW=$clog2(N_FRAMES).
- One natural sub-module: aco_hold_reg, the one-entry ready/valid holding register with overflow flag. The FSM and counters stay in the top level.

Test Plan:
- Nominal: en_i=1, 3 frames of 13 coefs 0x01..0x0D with coef_last_i on the 13th, ready_i=1 → 3 frames, data_o=0x0102..0D, frame_idx_o=0,1,2, err_o=0.
- Window wrap: 51 frames, ready_i=1 → last_o=1 only on frame_idx_o=49; frame 51 has idx 0, last_o=0.
- Short frame: coef_last_i on the 9th coef → err_o=1, pk_en_o=0 for exactly 1 cycle, no valid_o for that frame. The next good frame is delivered with the next index.
- Backpressure: ready_i=0 across 2 frames → the first is held stable, the second is dropped, err_o=1, drop_cnt_o=1 (stats build). After ready_i=1 the first is delivered and the next frame's idx skips by 2.
- Drain+load same cycle: ready_i pulsed on the pk_valid_i cycle → valid_o stays 1 and data_o switches to the new frame with no bubble.
- Async reset mid-frame after 6 coefs → all outputs 0 immediately; after release plus en_i, the next full frame has idx 0 and is correct.
